// File: rtl/mux_pc.sv
// Program-counter source mux with registered PC output and fetch-stall hold.
// Optional misalignment trap flag compiled in with `define MUX_PC_MISALIGN_EN.
module mux_pc #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             A0,
  input  logic             en,
  output logic [WIDTH-1:0] next_pc,
`ifdef MUX_PC_MISALIGN_EN
  output logic             misalign,
`endif
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] pc_q, pc_d;

  // AND-OR select so an X on A0 propagates instead of being resolved by an if/else
  assign next_pc = (I0 & ~{WIDTH{A0}}) | (I1 & {WIDTH{A0}});
  assign Q       = pc_q;

`ifdef MUX_PC_MISALIGN_EN
  logic misalign_q, misalign_d;

  assign misalign = misalign_q;

  // A non-word-aligned target is refused: the PC stays put and the trap flag is raised
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (en) begin
      if (next_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end else begin
        misalign_d = 1'b0;
        pc_d       = next_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end
`else
  always_comb begin
    pc_d = pc_q;
    if (en) begin
      pc_d = next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux_pc.sv
// Scoreboard bench for mux_pc: stimulus pushes expected PC state, a monitor pops and compares.
// Also exercises the misalign flag when MUX_PC_MISALIGN_EN is defined.
module tb_mux_pc;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;

  typedef struct {
    logic [WIDTH-1:0] pc;
    logic             mis;
  } expect_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] I0, I1;
  logic             A0, en;
  logic [WIDTH-1:0] next_pc, Q;
`ifdef MUX_PC_MISALIGN_EN
  logic             misalign;
`endif

  int total = 0;
  int bad   = 0;
  bit stimDone = 1'b0;

  expect_t sbQueue[$];

  // Reference state: the PC and trap flag as the architecture defines them
  logic [WIDTH-1:0] modelPc  = RV;
  logic             modelMis = 1'b0;

  mux_pc #(.WIDTH(WIDTH), .RESET_VECTOR(RV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .I0      (I0),
    .I1      (I1),
    .A0      (A0),
    .en      (en),
    .next_pc (next_pc),
`ifdef MUX_PC_MISALIGN_EN
    .misalign(misalign),
`endif
    .Q       (Q)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, required, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and predict the state after the next rising edge
  task automatic applyStimulus(input logic r, input logic e, input logic a,
                               input logic [WIDTH-1:0] i0, input logic [WIDTH-1:0] i1);
    logic [WIDTH-1:0] chosen;
    expect_t exp;
    @(negedge clk);
    rst_n = r; en = e; A0 = a; I0 = i0; I1 = i1;
    chosen = a ? i1 : i0;
    if (!r) begin
      modelPc  = RV;
      modelMis = 1'b0;
    end else if (e) begin
`ifdef MUX_PC_MISALIGN_EN
      if (chosen % 4 != 0) begin
        modelMis = 1'b1;
      end else begin
        modelMis = 1'b0;
        modelPc  = chosen;
      end
`else
      modelPc = chosen;
`endif
    end
    exp.pc  = modelPc;
    exp.mis = modelMis;
    sbQueue.push_back(exp);
    #1;
    checkOutput("next_pc", next_pc, chosen);
  endtask

  // Monitor: Q is presented every cycle, so compare one expectation per rising edge
  initial begin
    expect_t exp;
    forever begin
      @(posedge clk);
      #1;
      if (sbQueue.size() != 0) begin
        exp = sbQueue.pop_front();
        checkOutput("Q", Q, exp.pc);
`ifdef MUX_PC_MISALIGN_EN
        checkOutput("misalign", {31'b0, misalign}, {31'b0, exp.mis});
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; A0 = 1'b0; I0 = '0; I1 = '0;

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0100);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'hFFFF_FFF0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h8000_0010);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int a = 0; a < 2; a++)
          applyStimulus(1'b1, 1'b1, a[0], WIDTH'(i), WIDTH'(j));

    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000);
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0014, 32'h0000_0200);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0014, 32'h0000_0200);

    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0024, 32'h0000_0022);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0031, 32'h0000_0022);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0028, 32'h0000_0024);

    // Reset in the middle of a pending jump must still win
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEC);

    for (int n = 0; n < 300; n++) begin
      logic [WIDTH-1:0] r0, r1;
      r0 = $urandom();
      r1 = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        r0[1:0] = 2'b00;
        r1[1:0] = 2'b00;
      end
      applyStimulus($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, r0, r1);
    end

    stimDone = 1'b1;
    for (int w = 0; w < 10 && sbQueue.size() != 0; w++)
      @(posedge clk);
    #2;
    total++;
    if (sbQueue.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sbQueue.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
